// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pixel pipeline stages (convolution, pooling).
// Holds the default frame geometry, the pixel type and an unsigned max helper.
package cnn_pkg;

  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_ROW_SIZE  = 540;
  localparam int DEF_ROW_COUNT = 540;

  // Widest pixel the max helper handles; narrower pixels are zero-extended.
  localparam int MAX_WORD = 32;

  typedef logic [DEF_WORD_SIZE-1:0] pixel_t;

  function automatic logic [MAX_WORD-1:0] pixel_max(input logic [MAX_WORD-1:0] a,
                                                    input logic [MAX_WORD-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row line buffer for 2x2 pooling: one write port, one synchronous read
// port with enable; rd_data is registered and holds between reads.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = DEF_ROW_SIZE / 2,
  parameter int WIDTH = DEF_WORD_SIZE,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a raster pixel stream. Even rows
// store pair maxima in a half-row buffer; odd rows combine and emit.
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ROW_SIZE  = DEF_ROW_SIZE,
  parameter int ROW_COUNT = DEF_ROW_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 frame_done
);

  localparam int HALF   = ROW_SIZE / 2;
  localparam int COL_W  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int ROW_W  = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
  localparam int ADDR_W = (HALF > 1) ? $clog2(HALF) : 1;
  // Last row that completes a 2x2 block; a trailing even row never emits.
  localparam int LAST_OUT_ROW = (ROW_COUNT / 2) * 2 - 1;

  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(ROW_COUNT - 1);
  localparam logic [ROW_W-1:0] LAST_OUT_ROW_V = ROW_W'(LAST_OUT_ROW);

  if (ROW_SIZE % 2 != 0) begin : g_bad_row_size
    $error("max_pool_2x2: ROW_SIZE must be even");
  end

  // Stream protocol: in_valid qualifies in_pixel and in_sof; there is no ready,
  // every valid pixel is consumed. out_valid is a one-cycle strobe.
  logic [COL_W-1:0]     col_q, col_d, col_eff;
  logic [ROW_W-1:0]     row_q, row_d, row_eff;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic                 out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;
  logic                 frame_done_q, frame_done_d;

  logic                 sof;
  logic                 rd_en, wr_en;
  logic [ADDR_W-1:0]    buf_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic [WORD_SIZE-1:0] pair_max, pool_max;

  assign sof      = in_valid & in_sof;
  assign col_eff  = sof ? '0 : col_q;
  assign row_eff  = sof ? '0 : row_q;
  assign buf_addr = ADDR_W'(col_eff >> 1);
  assign pair_max = WORD_SIZE'(pixel_max(MAX_WORD'(hold_q), MAX_WORD'(in_pixel)));
  assign pool_max = WORD_SIZE'(pixel_max(MAX_WORD'(pair_max), MAX_WORD'(rd_data)));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_valid_d  = 1'b0;
    out_pixel_d  = out_pixel_q;
    frame_done_d = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    if (in_valid) begin
      if (!col_eff[0]) begin
        hold_d = in_pixel;
        rd_en  = row_eff[0];
      end else if (!row_eff[0]) begin
        wr_en = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_pixel_d  = pool_max;
        frame_done_d = (col_eff == LAST_COL) && (row_eff == LAST_OUT_ROW_V);
      end
      if (col_eff == LAST_COL) begin
        col_d = '0;
        row_d = (row_eff == LAST_ROW) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  pool_line_buffer #(
    .DEPTH (HALF),
    .WIDTH (WORD_SIZE)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (buf_addr),
    .wr_data (pair_max),
    .rd_en   (rd_en),
    .rd_addr (buf_addr),
    .rd_data (rd_data)
  );

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: three instances (4x4, 4x3, 12x7) checked against a
// frame-array model plus constant tables for the hand-picked cases.
module tb_max_pool_2x2;

  logic clk;
  logic rst      [3];
  logic in_valid [3];
  logic in_sof   [3];
  logic [7:0] in_pixel [3];

  logic ov_a, ov_b, ov_c, fd_a, fd_b, fd_c;
  logic [7:0] op_a, op_b, op_c;

  int vectors = 0;
  int miscompares = 0;

  int rs_t [3] = '{4, 4, 12};
  int rc_t [3] = '{4, 3, 7};

  // Reference model state: whole-frame pixel store and raster position.
  logic [7:0] fr [3][7][12];
  int mr [3];
  int mc [3];
  bit due [3];
  logic [8:0] exp_q [3][$];
  logic [7:0] got_q [3][$];
  int fd_cnt [3];

  typedef struct packed {
    logic [3:0][7:0] blk;  // blk[0]=(r0,c0) blk[1]=(r0,c1) blk[2]=(r1,c0) blk[3]=(r1,c1)
    logic [7:0]      exp;
  } vec_t;
  vec_t tbl [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .ROW_COUNT(4)) dut_a (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_sof(in_sof[0]),
    .in_pixel(in_pixel[0]), .out_valid(ov_a), .out_pixel(op_a), .frame_done(fd_a));
  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .ROW_COUNT(3)) dut_b (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_sof(in_sof[1]),
    .in_pixel(in_pixel[1]), .out_valid(ov_b), .out_pixel(op_b), .frame_done(fd_b));
  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(12), .ROW_COUNT(7)) dut_c (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_sof(in_sof[2]),
    .in_pixel(in_pixel[2]), .out_valid(ov_c), .out_pixel(op_c), .frame_done(fd_c));

  function automatic logic [9:0] outs(input int d);
    case (d)
      0:       return {ov_a, fd_a, op_a};
      1:       return {ov_b, fd_b, op_b};
      default: return {ov_c, fd_c, op_c};
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Model: store the pixel at its raster position; a pixel at (odd row, odd
  // col) closes a 2x2 block whose max is due on the next cycle.
  task automatic model_accept(input int d, input logic [7:0] px, input logic sof);
    int mx;
    bit fd;
    if (sof) begin
      mr[d] = 0;
      mc[d] = 0;
    end
    fr[d][mr[d]][mc[d]] = px;
    if (mr[d] % 2 == 1 && mc[d] % 2 == 1) begin
      mx = 0;
      for (int r = mr[d] - 1; r <= mr[d]; r++)
        for (int c = mc[d] - 1; c <= mc[d]; c++)
          if (int'(fr[d][r][c]) > mx) mx = int'(fr[d][r][c]);
      fd = (mr[d] == (rc_t[d] / 2) * 2 - 1) && (mc[d] == rs_t[d] - 1);
      exp_q[d].push_back({fd, mx[7:0]});
      due[d] = 1'b1;
    end
    mc[d]++;
    if (mc[d] == rs_t[d]) begin
      mc[d] = 0;
      mr[d]++;
      if (mr[d] == rc_t[d]) mr[d] = 0;
    end
  endtask

  task automatic mon(input int d);
    logic [9:0] o;
    logic [8:0] e;
    o = outs(d);
    vectors++;
    if (o[9] !== due[d] || (!o[9] && o[8] !== 1'b0)) begin
      miscompares++;
      $display("FAIL strobe dut%0d t=%0t: out_valid=%b frame_done=%b, required out_valid=%b",
               d, $time, o[9], o[8], due[d]);
    end
    if (o[9] === 1'b1) begin
      got_q[d].push_back(o[7:0]);
      if (o[8] === 1'b1) fd_cnt[d]++;
      vectors++;
      if (exp_q[d].size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out dut%0d: got pixel %0d, required no output", d, o[7:0]);
      end else begin
        e = exp_q[d].pop_front();
        if (o[8:0] !== e) begin
          miscompares++;
          $display("FAIL pool_out dut%0d t=%0t: got px=%0d fd=%b, required px=%0d fd=%b",
                   d, $time, o[7:0], o[8], e[7:0], e[8]);
        end
      end
    end
    due[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    mon(2);
  end

  task automatic drive(input int d, input logic [7:0] px, input logic sof);
    in_valid[d] = 1'b1;
    in_sof[d]   = sof;
    in_pixel[d] = px;
    @(posedge clk);
    model_accept(d, px, sof);
    #1;
    in_valid[d] = 1'b0;
    in_sof[d]   = 1'b0;
    in_pixel[d] = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b0;
    @(posedge clk);
    mr[d] = 0;
    mc[d] = 0;
    due[d] = 1'b0;
    exp_q[d].delete();
    #1;
    rst[d] = 1'b1;
    @(negedge clk);
    cmp($sformatf("reset_outs_dut%0d", d), int'(outs(d)), 0);
  endtask

  // mode 0: pixel = raster index; mode 1: random pixels.
  task automatic run_frame(input int d, input int mode, input int max_gap, input logic use_sof);
    int n;
    n = rs_t[d] * rc_t[d];
    for (int i = 0; i < n; i++) begin
      drive(d, (mode == 0) ? 8'(i) : 8'($urandom), use_sof && (i == 0));
      if (max_gap > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, max_gap));
    end
  endtask

  task automatic clear_got(input int d);
    idle(1);
    got_q[d].delete();
    fd_cnt[d] = 0;
  endtask

  task automatic check_got(input int d, input string name, input int n,
                           input logic [3:0][7:0] vals, input int fds);
    idle(1);
    cmp({name, "_count"}, got_q[d].size(), n);
    for (int i = 0; i < n && i < got_q[d].size(); i++)
      cmp($sformatf("%s_px%0d", name, i), int'(got_q[d][i]), int'(vals[i]));
    cmp({name, "_frame_done"}, fd_cnt[d], fds);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      in_valid[d] = 1'b0;
      in_sof[d] = 1'b0;
      in_pixel[d] = '0;
      mr[d] = 0;
      mc[d] = 0;
      due[d] = 1'b0;
      fd_cnt[d] = 0;
    end
    for (int d = 0; d < 3; d++) do_reset(d);

    // Constant table for the max-selection corners.
    tbl[0].blk = {8'd0, 8'd0, 8'd0, 8'd255};   tbl[0].exp = 8'd255;
    tbl[1].blk = {8'd200, 8'd0, 8'd0, 8'd0};   tbl[1].exp = 8'd200;
    tbl[2].blk = '0;                           tbl[2].exp = 8'd0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) tbl[3 + p].blk[k] = 8'($urandom_range(0, 127));
      tbl[3 + p].blk[p] = 8'd128;
      tbl[3 + p].exp = 8'd128;
    end

    // 4x4 raster 0..15, continuous then with gaps.
    clear_got(0);
    run_frame(0, 0, 0, 1'b1);
    check_got(0, "a_seq", 4, {8'd15, 8'd13, 8'd7, 8'd5}, 1);
    clear_got(0);
    run_frame(0, 0, 3, 1'b1);
    check_got(0, "a_gaps", 4, {8'd15, 8'd13, 8'd7, 8'd5}, 1);

    // Max-selection corners in block (0,0) of an otherwise random frame.
    for (int t = 0; t < 7; t++) begin
      clear_got(0);
      for (int i = 0; i < 16; i++) begin
        int r, c;
        r = i / 4;
        c = i % 4;
        drive(0, (r < 2 && c < 2) ? tbl[t].blk[r * 2 + c] : 8'($urandom), i == 0);
      end
      idle(1);
      cmp($sformatf("corner%0d_count", t), got_q[0].size(), 4);
      if (got_q[0].size() > 0) cmp($sformatf("corner%0d_max", t), int'(got_q[0][0]), int'(tbl[t].exp));
    end

    // Mid-frame resync by in_sof, then by reset.
    for (int i = 0; i < 6; i++) drive(0, 8'($urandom), i == 0);
    clear_got(0);
    run_frame(0, 0, 0, 1'b1);
    check_got(0, "a_sof_resync", 4, {8'd15, 8'd13, 8'd7, 8'd5}, 1);
    for (int i = 0; i < 6; i++) drive(0, 8'($urandom), i == 0);
    idle(1);
    do_reset(0);
    clear_got(0);
    run_frame(0, 0, 0, 1'b0);
    check_got(0, "a_rst_resync", 4, {8'd15, 8'd13, 8'd7, 8'd5}, 1);

    // Odd row count: the trailing row emits nothing; next frame still correct.
    clear_got(1);
    run_frame(1, 0, 0, 1'b1);
    check_got(1, "b_seq", 2, {8'd0, 8'd0, 8'd7, 8'd5}, 1);
    clear_got(1);
    run_frame(1, 1, 2, 1'b1);
    idle(1);
    cmp("b_rand_count", got_q[1].size(), 2);
    cmp("b_rand_frame_done", fd_cnt[1], 1);

    // Back-to-back random frames on 12x7 against the model.
    clear_got(2);
    run_frame(2, 1, 0, 1'b1);
    run_frame(2, 1, 3, 1'b0);
    run_frame(2, 1, 0, 1'b1);
    idle(2);
    cmp("c_out_count", got_q[2].size(), 3 * 6 * 3);
    cmp("c_frame_done", fd_cnt[2], 3);

    idle(2);
    for (int d = 0; d < 3; d++) cmp($sformatf("pending_dut%0d", d), exp_q[d].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
